// File: rtl/tiny_rv_pkg.sv
// Shared RV32I decode constants, immediate formats and the register-read stage record.
// Used by the register-read stage and by exec.
package tiny_rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm32;
  } rr_t;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_fmt = FMT_I;
      OPC_STORE:                      imm_fmt = FMT_S;
      OPC_BRANCH:                     imm_fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:             imm_fmt = FMT_U;
      OPC_JAL:                        imm_fmt = FMT_J;
      default:                        imm_fmt = FMT_NONE;
    endcase
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] inst);
    case (imm_fmt(inst[6:0]))
      FMT_I:   imm_gen = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm_gen = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm_gen = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm_gen = {inst[31:12], 12'd0};
      FMT_J:   imm_gen = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm_gen = 32'd0;
    endcase
  endfunction

  // A bubble keeps the PC so exec still sees a coherent address.
  function automatic rr_t rr_bubble(input logic [31:0] pc);
    rr_bubble        = '0;
    rr_bubble.pc     = pc;
    rr_bubble.inst   = NOP_INST;
    rr_bubble.opcode = OPC_OP_IMM;
  endfunction

endpackage

// File: rtl/tiny_rv_regfile.sv
// 31x32 register file: two asynchronous write-first read ports, one synchronous write port.
// x0 has no storage and always reads zero; contents are never reset.
module tiny_rv_regfile (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] mem_q [1:31];

  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i != 5'd0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = 32'd0;
    if (raddr1_i != 5'd0) begin
      rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : mem_q[raddr1_i];
    end
  end

  always_comb begin
    rdata2_o = 32'd0;
    if (raddr2_i != 5'd0) begin
      rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : mem_q[raddr2_i];
    end
  end

endmodule

// File: rtl/tiny_rv_rr.sv
// Register-read stage: decodes, reads operands, detects RAW hazards on exec, issues bubbles.
// Define TINY_RV_RR_BYPASS_EN to forward exec_rd_val instead of stalling on exec_rd.
module tiny_rv_rr
  import tiny_rv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        dec_valid,
  input  logic [31:0] dec_pc,
  input  logic [31:0] dec_inst,
  output logic        rr_dec_stall,
  input  logic        exec_rr_stall,
  input  logic        exec_rr_flush,
  input  logic [4:0]  exec_rd,
  input  logic [31:0] exec_rd_val,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_val,
  output logic [31:0] rr_pc,
  output logic [31:0] rr_inst,
  output logic [6:0]  rr_opcode,
  output logic [4:0]  rr_rd,
  output logic [31:0] rr_rs1,
  output logic [31:0] rr_rs2,
  output logic [2:0]  rr_funct3,
  output logic [6:0]  rr_funct7,
  output logic [31:0] rr_imm32
);

  rr_t         rr_q, rr_d, cap;
  logic [6:0]  opcode;
  logic [4:0]  rs1_idx, rs2_idx;
  logic        rs1_used, rs2_used;
  logic [31:0] rf_rd1, rf_rd2, src1_val, src2_val;
  logic        hit1, hit2, hazard;

  assign opcode  = dec_inst[6:0];
  assign rs1_idx = dec_inst[19:15];
  assign rs2_idx = dec_inst[24:20];

  assign rs1_used = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL))
                    && (rs1_idx != 5'd0);
  assign rs2_used = ((opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP))
                    && (rs2_idx != 5'd0);

  tiny_rv_regfile u_regfile (
    .clk_i    (i_clk),
    .we_i     (wb_we),
    .waddr_i  (wb_rd),
    .wdata_i  (wb_val),
    .raddr1_i (rs1_idx),
    .raddr2_i (rs2_idx),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2)
  );

`ifdef TINY_RV_RR_BYPASS_EN
  assign src1_val = ((exec_rd != 5'd0) && (rs1_idx == exec_rd)) ? exec_rd_val : rf_rd1;
  assign src2_val = ((exec_rd != 5'd0) && (rs2_idx == exec_rd)) ? exec_rd_val : rf_rd2;
  assign hit1     = rs1_used && (rs1_idx == rr_q.rd);
  assign hit2     = rs2_used && (rs2_idx == rr_q.rd);
`else
  logic unused_exec_val;
  assign unused_exec_val = ^exec_rd_val;
  assign src1_val = rf_rd1;
  assign src2_val = rf_rd2;
  // Without forwarding, a producer still sitting in exec's result register must be waited out.
  assign hit1     = rs1_used && ((rs1_idx == rr_q.rd) || (rs1_idx == exec_rd));
  assign hit2     = rs2_used && ((rs2_idx == rr_q.rd) || (rs2_idx == exec_rd));
`endif

  assign hazard = dec_valid && (hit1 || hit2);

  always_comb begin
    cap        = '0;
    cap.pc     = dec_pc;
    cap.inst   = dec_inst;
    cap.opcode = opcode;
    cap.rd     = dec_inst[11:7];
    cap.rs1    = rs1_used ? src1_val : 32'd0;
    cap.rs2    = rs2_used ? src2_val : 32'd0;
    cap.funct3 = dec_inst[14:12];
    cap.funct7 = dec_inst[31:25];
    cap.imm32  = imm_gen(dec_inst);
  end

  // Priority: flush, exec stall, hazard, empty decode, capture.
  always_comb begin
    rr_d         = rr_q;
    rr_dec_stall = 1'b0;
    if (exec_rr_flush) begin
      rr_d = rr_bubble(rr_q.pc);
    end else if (exec_rr_stall) begin
      rr_dec_stall = 1'b1;
    end else if (hazard) begin
      rr_d         = rr_bubble(rr_q.pc);
      rr_dec_stall = 1'b1;
    end else if (!dec_valid) begin
      rr_d = rr_bubble(rr_q.pc);
    end else begin
      rr_d = cap;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      rr_q <= rr_bubble(32'd0);
    end else begin
      rr_q <= rr_d;
    end
  end

  assign rr_pc     = rr_q.pc;
  assign rr_inst   = rr_q.inst;
  assign rr_opcode = rr_q.opcode;
  assign rr_rd     = rr_q.rd;
  assign rr_rs1    = rr_q.rs1;
  assign rr_rs2    = rr_q.rs2;
  assign rr_funct3 = rr_q.funct3;
  assign rr_funct7 = rr_q.funct7;
  assign rr_imm32  = rr_q.imm32;

endmodule

// File: tb/tb_tiny_rv_rr.sv
// Self-checking bench for tiny_rv_rr: vector table plus hand sequences for stall/flush/hazard/reset.
module tb_tiny_rv_rr;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        dec_valid;
  logic [31:0] dec_pc, dec_inst;
  logic        rr_dec_stall;
  logic        exec_rr_stall, exec_rr_flush;
  logic [4:0]  exec_rd;
  logic [31:0] exec_rd_val;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;
  logic [31:0] rr_pc, rr_inst, rr_rs1, rr_rs2, rr_imm32;
  logic [6:0]  rr_opcode, rr_funct7;
  logic [4:0]  rr_rd;
  logic [2:0]  rr_funct3;

  always #5 i_clk = ~i_clk;

  tiny_rv_rr dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_inst(dec_inst), .rr_dec_stall(rr_dec_stall),
    .exec_rr_stall(exec_rr_stall), .exec_rr_flush(exec_rr_flush),
    .exec_rd(exec_rd), .exec_rd_val(exec_rd_val),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_val(wb_val),
    .rr_pc(rr_pc), .rr_inst(rr_inst), .rr_opcode(rr_opcode), .rr_rd(rr_rd),
    .rr_rs1(rr_rs1), .rr_rs2(rr_rs2), .rr_funct3(rr_funct3), .rr_funct7(rr_funct7),
    .rr_imm32(rr_imm32)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } exp_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } vec_t;

  localparam logic [31:0] I_ADD3   = 32'h0020_81B3; // add  x3,x1,x2
  localparam logic [31:0] I_ADDI5  = 32'hFFF0_0293; // addi x5,x0,-1
  localparam logic [31:0] I_ADD6_5 = 32'h0052_8333; // add  x6,x5,x5
  localparam logic [31:0] I_ADD6_3 = 32'h0031_8333; // add  x6,x3,x3
  localparam logic [31:0] I_BEQ    = 32'hFE00_0FE3; // beq  x0,x0,-2
  localparam logic [31:0] I_ADDI1  = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_ADD14  = 32'h0016_8733; // add  x14,x13,x1
  localparam logic [31:0] I_ADD4_0 = 32'h0000_0233; // add  x4,x0,x0

  exp_t sb_q[$];
  vec_t vecs[12];
  int   checks = 0;
  int   passed = 0;
  exp_t beq_rec;
  logic [31:0] last_pc;

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] inst,
                              input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2);
    exp_t e;
    e.pc = pc; e.inst = inst; e.opcode = inst[6:0]; e.rd = inst[11:7];
    e.rs1 = rs1; e.rs2 = rs2; e.f3 = inst[14:12]; e.f7 = inst[31:25]; e.imm = imm;
    return e;
  endfunction

  function automatic exp_t bub(input logic [31:0] pc);
    exp_t e;
    e = '0;
    e.pc = pc; e.inst = 32'h0000_0013; e.opcode = 7'h13;
    return e;
  endfunction

  task automatic check_rr(input string name);
    exp_t e, a;
    checks++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb_q.pop_front();
    a = {rr_pc, rr_inst, rr_opcode, rr_rd, rr_rs1, rr_rs2, rr_funct3, rr_funct7, rr_imm32};
    if (a === e) passed++;
    else $display("FAIL %s: got pc=%h inst=%h op=%h rd=%0d rs1=%h rs2=%h f3=%0d f7=%h imm=%h want pc=%h inst=%h op=%h rd=%0d rs1=%h rs2=%h f3=%0d f7=%h imm=%h",
                  name, a.pc, a.inst, a.opcode, a.rd, a.rs1, a.rs2, a.f3, a.f7, a.imm,
                  e.pc, e.inst, e.opcode, e.rd, e.rs1, e.rs2, e.f3, e.f7, e.imm);
  endtask

  // Present one decode slot, check the combinational stall, then the registered result.
  task automatic apply(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic exp_stall, input exp_t exp, input string name);
    dec_valid = v; dec_pc = pc; dec_inst = inst;
    #1;
    checks++;
    if (rr_dec_stall === exp_stall) passed++;
    else $display("FAIL %s stall: got %b want %b", name, rr_dec_stall, exp_stall);
    sb_q.push_back(exp);
    @(posedge i_clk);
    #1;
    check_rr(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h100, I_ADD3,       32'h0,        32'h11,       32'h22};
    vecs[1]  = '{1'b1, 32'h104, 32'hABCDE0B7, 32'hABCDE000, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 32'h108, I_BEQ,        32'hFFFFFFFE, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 32'h10C, I_ADD3,       32'h0,        32'h0,        32'h0};
    vecs[4]  = '{1'b1, 32'h110, 32'h7FF50213, 32'h7FF,      32'h12345678, 32'h0};
    vecs[5]  = '{1'b1, 32'h114, 32'hFEB52E23, 32'hFFFFFFFC, 32'h12345678, 32'h80000000};
    vecs[6]  = '{1'b1, 32'h118, 32'h001000EF, 32'h800,      32'h0,        32'h0};
    vecs[7]  = '{1'b1, 32'h11C, 32'h80000397, 32'h80000000, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 32'h120, 32'h123453B7, 32'h12345000, 32'h0,        32'h0};
    vecs[9]  = '{1'b1, 32'h124, 32'h00A5E433, 32'h0,        32'h80000000, 32'h12345678};
    vecs[10] = '{1'b1, 32'h128, 32'h401104B3, 32'h0,        32'h22,       32'h11};
    vecs[11] = '{1'b1, 32'h12C, 32'h80012603, 32'hFFFFF800, 32'h22,       32'h0};

    i_reset = 1'b0; dec_valid = 1'b0; dec_pc = '0; dec_inst = '0;
    exec_rr_stall = 1'b0; exec_rr_flush = 1'b0; exec_rd = '0; exec_rd_val = '0;
    wb_we = 1'b0; wb_rd = '0; wb_val = '0;
    @(posedge i_clk); #1;
    apply(1'b0, 32'h0, 32'h0, 1'b0, bub(32'h0), "reset0");
    apply(1'b0, 32'h0, 32'h0, 1'b0, bub(32'h0), "reset1");
    i_reset = 1'b1;

    wb_we = 1'b1;
    wb_rd = 5'd1;  wb_val = 32'h11;       apply(1'b0, 32'h0, 32'h0, 1'b0, bub(32'h0), "wb_x1");
    wb_rd = 5'd2;  wb_val = 32'h22;       apply(1'b0, 32'h0, 32'h0, 1'b0, bub(32'h0), "wb_x2");
    wb_rd = 5'd10; wb_val = 32'h12345678; apply(1'b0, 32'h0, 32'h0, 1'b0, bub(32'h0), "wb_x10");
    wb_rd = 5'd11; wb_val = 32'h80000000; apply(1'b0, 32'h0, 32'h0, 1'b0, bub(32'h0), "wb_x11");
    wb_we = 1'b0;

    last_pc = 32'h0;
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].valid) begin
        apply(1'b1, vecs[i].pc, vecs[i].inst, 1'b0,
              mk(vecs[i].pc, vecs[i].inst, vecs[i].imm, vecs[i].rs1, vecs[i].rs2),
              $sformatf("vec%0d", i));
        last_pc = vecs[i].pc;
      end else begin
        apply(1'b0, vecs[i].pc, vecs[i].inst, 1'b0, bub(last_pc), $sformatf("vec%0d", i));
      end
    end

    wb_we = 1'b1; wb_rd = 5'd13; wb_val = 32'hCAFEF00D;
    apply(1'b1, 32'h130, I_ADD14, 1'b0, mk(32'h130, I_ADD14, 32'h0, 32'hCAFEF00D, 32'h11), "wb_first");
    wb_we = 1'b0;

    apply(1'b1, 32'h200, I_ADDI5, 1'b0, mk(32'h200, I_ADDI5, 32'hFFFFFFFF, 32'h0, 32'h0), "raw_addi");
    apply(1'b1, 32'h204, I_ADD6_5, 1'b1, bub(32'h200), "raw_bubble");
    exec_rd = 5'd5; exec_rd_val = 32'hFFFFFFFF;
`ifdef TINY_RV_RR_BYPASS_EN
    apply(1'b1, 32'h204, I_ADD6_5, 1'b0,
          mk(32'h204, I_ADD6_5, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF), "raw_bypass");
    exec_rd = 5'd0;
`else
    apply(1'b1, 32'h204, I_ADD6_5, 1'b1, bub(32'h200), "raw_bubble2");
    exec_rd = 5'd0;
    wb_we = 1'b1; wb_rd = 5'd5; wb_val = 32'hFFFFFFFF;
    apply(1'b1, 32'h204, I_ADD6_5, 1'b0,
          mk(32'h204, I_ADD6_5, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF), "raw_wb");
    wb_we = 1'b0;
`endif

    beq_rec = mk(32'h300, I_BEQ, 32'hFFFFFFFE, 32'h0, 32'h0);
    apply(1'b1, 32'h300, I_BEQ, 1'b0, beq_rec, "beq_issue");
    exec_rr_stall = 1'b1;
    for (int k = 0; k < 3; k++) apply(1'b1, 32'h304, I_ADD3, 1'b1, beq_rec, $sformatf("hold%0d", k));
    exec_rr_stall = 1'b0;
    apply(1'b1, 32'h304, I_ADD3, 1'b0, mk(32'h304, I_ADD3, 32'h0, 32'h11, 32'h22), "hold_release");

    exec_rr_stall = 1'b1; exec_rr_flush = 1'b1;
    apply(1'b1, 32'h308, I_ADD6_3, 1'b0, bub(32'h304), "flush");
    exec_rr_stall = 1'b0; exec_rr_flush = 1'b0;
    apply(1'b0, 32'h30C, I_ADD3, 1'b0, bub(32'h304), "post_flush");

    apply(1'b1, 32'h400, I_ADDI1, 1'b0, mk(32'h400, I_ADDI1, 32'h5, 32'h0, 32'h0), "rst_addi");
    i_reset = 1'b0;
    apply(1'b1, 32'h404, I_ADD3, 1'b1, bub(32'h0), "rst_hazard");
    i_reset = 1'b1;
    apply(1'b1, 32'h404, I_ADD3, 1'b0, mk(32'h404, I_ADD3, 32'h0, 32'h11, 32'h22), "rst_after");

    wb_we = 1'b1; wb_rd = 5'd0; wb_val = 32'h5;
    apply(1'b1, 32'h500, I_ADD4_0, 1'b0, mk(32'h500, I_ADD4_0, 32'h0, 32'h0, 32'h0), "x0_write");
    wb_we = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tiny_rv_rr.md
TINY_RV_RR -- requirements
Module: tiny_rv_rr

Interface
REQ-001 SHALL have ports: i_clk input 1 clock; i_reset input 1 synchronous reset, active-low (asserted when 0); one clock domain.
REQ-002 SHALL have ports: dec_valid input 1 decode holds an instruction; dec_pc input 32 its PC; dec_inst input 32 its encoding; rr_dec_stall output 1 decode must hold dec_*.
REQ-003 SHALL have ports: exec_rr_stall input 1 exec cannot accept; exec_rr_flush input 1 redirect, discard younger work.
REQ-004 SHALL have ports: exec_rd input 5 and exec_rd_val input 32, exec stage result register (rd=0 means no write).
REQ-005 SHALL have ports: wb_we input 1, wb_rd input 5, wb_val input 32, register-file write port.
REQ-006 SHALL have registered outputs: rr_pc 32, rr_inst 32, rr_opcode 7, rr_rd 5, rr_rs1 32 (value), rr_rs2 32 (value), rr_funct3 3, rr_funct7 7, rr_imm32 32.

Function
REQ-007 SHALL decode dec_inst: opcode [6:0], rd [11:7], funct3 [14:12], rs1 idx [19:15], rs2 idx [24:20], funct7 [31:25].
REQ-008 SHALL sign-extend imm32 by opcode format: I (OP-IMM, LOAD, JALR), S (STORE), B (BRANCH, bit0=0), U (LUI, AUIPC, low 12 zero), J (JAL, bit0=0); other opcodes 0.
REQ-009 SHALL treat rs1 as used except for LUI, AUIPC, JAL; rs2 used only for BRANCH, STORE, OP; index 0 never used.
REQ-010 SHALL read x0 as 0; register write with wb_rd=0 ignored.
REQ-011 SHALL read write-first: wb_we with wb_rd matching a source index this cycle returns wb_val.
REQ-012 SHALL define bubble: rr_inst=0x00000013, rr_opcode=OP-IMM, rr_rd=0, rr_imm32=0, rr_rs1=rr_rs2=0, rr_funct3=rr_funct7=0, rr_pc unchanged.
REQ-013 SHALL detect hazard when a used source index equals nonzero rr_rd (instruction now in exec).
REQ-014 On hazard (no flush, no exec stall): load bubble into rr_*, assert rr_dec_stall, keep dec_*; next cycle reissue.
REQ-015 exec_rr_stall=1 (no flush): hold all rr_* unchanged, assert rr_dec_stall.
REQ-016 exec_rr_flush=1: load bubble, rr_dec_stall=0 (decode advances to redirected stream), dec_* of this cycle discarded; flush overrides stall and hazard.
REQ-017 dec_valid=0 with no stall/flush: load bubble, rr_dec_stall=0.
REQ-018 Otherwise SHALL capture decoded fields and operand values in one cycle (latency 1), rr_dec_stall=0.
REQ-019 rr_dec_stall SHALL be combinational from current inputs and rr_rd.

Reset
REQ-020 While i_reset=0 at a clock edge: rr_* = bubble with rr_pc=0; register file contents other than x0 undefined, not reset.
REQ-021 Reset mid-stall or mid-hazard SHALL drop the held instruction; first post-reset cycle behaves per REQ-017/018.

Configuration
REQ-022 Macro TINY_RV_RR_BYPASS_EN defined: source matching nonzero exec_rd SHALL read exec_rd_val (priority exec_rd > wb > regfile).
REQ-023 Macro undefined: source matching nonzero exec_rd SHALL also be a hazard (REQ-014), no forwarding path; wb write-first retained.

Structure
REQ-024 Opcode constants, NOP encoding 0x00000013, and immediate-format enum SHALL live in shared package tiny_rv_pkg, reused by exec.
REQ-025 Register file SHALL be sub-module tiny_rv_regfile: 31x32 storage, 2 async read ports, 1 sync write port, x0 hardwired.

Verification
REQ-026 wb writes x1=0x11, x2=0x22; issue ADD x3,x1,x2 -> next cycle rr_rs1=0x11, rr_rs2=0x22, rr_rd=3, rr_dec_stall=0.
REQ-027 ADDI x5,x0,-1 then ADD x6,x5,x5 -> cycle 2 bubble with rr_dec_stall=1; cycle 3 (BYPASS_EN, exec_rd=5, exec_rd_val=0xFFFFFFFF) rr_rs1=rr_rs2=0xFFFFFFFF; without BYPASS_EN one more bubble, value from wb.
REQ-028 exec_rr_stall=1 for 3 cycles with BEQ in rr -> rr_* constant, rr_dec_stall=1 all 3 cycles.
REQ-029 exec_rr_flush=1 concurrent with exec_rr_stall=1 and hazard -> next rr_inst=0x00000013, rr_rd=0, rr_dec_stall=0.
REQ-030 Immediates: dec_inst=0xFE000FE3 (BEQ x0,x0,-2) -> rr_imm32=0xFFFFFFFE; LUI x1,0xABCDE -> rr_imm32=0xABCDE000; LUI x7 with x7==rr_rd -> no stall.
REQ-031 i_reset=0 during hazard stall -> rr_pc=0, bubble outputs; ADD x0 with wb_we=1, wb_rd=0, wb_val=5 -> x0 reads 0.
